// File: rtl/wb_user_slave_arbiter.sv
// wb_user_slave_arbiter
//   Wishbone slave-side controller between the management SoC port and up to
//   NSLV user slaves. It decodes the user window, runs one transaction at a
//   time to the selected slave, and returns a registered response. Every
//   access is bounded by an ack timeout. It records the last fault address and
//   keeps a saturating fault count.
//
//   Optional feature macro: WB_ARB_TIMEOUT_IRQ_EN. When defined, irq_o is a
//   sticky timeout flag. When undefined, irq_o is tied low.
//
//   Ports
//     wb_clk_i, wb_rst_ni           : clock, async active-low reset
//     wbs_cyc/stb/we/sel/adr/dat_i  : master request
//     wbs_ack_o, wbs_dat_o          : master response (registered)
//     s_cyc_o[NSLV]                 : one-hot slave cycle
//     s_stb/we/sel/adr/dat_o        : shared slave request
//     s_ack_i[NSLV], s_dat_i        : per-slave ack, packed read data
//     err_o, err_adr_o, err_cnt_o   : sticky fault flag, last fault address, count
//     err_clr_i                     : synchronous clear of err_o/err_cnt_o/irq_o
//     irq_o                         : timeout interrupt
module wb_user_slave_arbiter #(
  parameter int unsigned NSLV     = 4,
  parameter logic [11:0] BASE_HI  = 12'h300,
  parameter int unsigned SLOT_LSB = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [32*NSLV-1:0]   s_dat_i,
  output logic                 err_o,
  output logic [31:0]          err_adr_o,
  output logic [15:0]          err_cnt_o,
  input  logic                 err_clr_i,
  output logic                 irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]      state_q,   state_d;
  logic [15:0]     cnt_q,     cnt_d;
  logic [31:0]     adr_q,     adr_d;
  logic [31:0]     wdat_q,    wdat_d;
  logic [3:0]      sel_q,     sel_d;
  logic            we_q,      we_d;
  logic [NSLV-1:0] s_cyc_q,   s_cyc_d;
  logic            s_stb_q,   s_stb_d;
  logic [31:0]     rdat_q,    rdat_d;
  logic            fault_q,   fault_d;
  logic            ack_q,     ack_d;
  logic [31:0]     dat_q,     dat_d;
  logic            err_q,     err_d;
  logic [31:0]     err_adr_q, err_adr_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic [2:0]  slot_in;
  logic        mapped_in;
  logic        ack_sel;
  logic [31:0] rdat_sel;
  logic        timeout_hit;
  logic        fault_set;
  logic [31:0] fault_adr;

  assign slot_in   = wbs_adr_i[SLOT_LSB+2:SLOT_LSB];
  assign mapped_in = (wbs_adr_i[31:20] == BASE_HI) && (32'(slot_in) < NSLV);

  // s_cyc_q is one-hot, so masking with it selects the addressed slave and
  // ignores acks from every other slot.
  assign ack_sel = |(s_cyc_q & s_ack_i);

  always_comb begin
    rdat_sel = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (s_cyc_q[k]) rdat_sel = s_dat_i[32*k +: 32];
    end
  end

  assign timeout_hit = (state_q == ST_WAIT) && wbs_cyc_i && !ack_sel &&
                       (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    s_cyc_d   = s_cyc_q;
    s_stb_d   = s_stb_q;
    rdat_d    = rdat_q;
    fault_d   = fault_q;
    ack_d     = 1'b0;
    dat_d     = '0;
    fault_set = 1'b0;
    fault_adr = adr_q;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d  = wbs_adr_i;
          wdat_d = wbs_dat_i;
          sel_d  = wbs_sel_i;
          we_d   = wbs_we_i;
          rdat_d = '0;
          cnt_d  = '0;
          if (mapped_in) begin
            for (int unsigned k = 0; k < NSLV; k++) s_cyc_d[k] = (32'(slot_in) == k);
            s_stb_d = 1'b1;
            fault_d = 1'b0;
            state_d = ST_WAIT;
          end else begin
            fault_d   = 1'b1;
            fault_set = 1'b1;
            fault_adr = wbs_adr_i;
            state_d   = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          s_cyc_d = '0;
          s_stb_d = 1'b0;
          state_d = ST_IDLE;
        end else if (ack_sel) begin
          rdat_d  = rdat_sel;
          s_cyc_d = '0;
          s_stb_d = 1'b0;
          fault_d = 1'b0;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          s_cyc_d   = '0;
          s_stb_d   = 1'b0;
          fault_d   = 1'b1;
          fault_set = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        ack_d   = 1'b1;
        dat_d   = fault_q ? ERR_DATA : rdat_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fault in the same cycle as err_clr_i wins: the count restarts at 1.
  always_comb begin
    err_d     = err_q;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    if (fault_set) begin
      err_d     = 1'b1;
      err_adr_d = fault_adr;
      if (err_clr_i)                   err_cnt_d = 16'd1;
      else if (err_cnt_q != 16'hFFFF)  err_cnt_d = err_cnt_q + 16'd1;
    end else if (err_clr_i) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      s_cyc_q   <= '0;
      s_stb_q   <= 1'b0;
      rdat_q    <= '0;
      fault_q   <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      s_cyc_q   <= s_cyc_d;
      s_stb_q   <= s_stb_d;
      rdat_q    <= rdat_d;
      fault_q   <= fault_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (timeout_hit)    irq_d = 1'b1;
    else if (err_clr_i) irq_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) irq_q <= 1'b0;
    else            irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = wdat_q;
  assign err_o     = err_q;
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_user_slave_arbiter.sv
// Directed bench for wb_user_slave_arbiter (NSLV=4, TIMEOUT=8).
module tb_wb_user_slave_arbiter;

  localparam int unsigned NSLV = 4;

`ifdef WB_ARB_TIMEOUT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              cyc, stb, we, err_clr;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NSLV-1:0]   s_cyc_o;
  logic              s_stb_o, s_we_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [NSLV-1:0]   s_ack;
  logic [32*NSLV-1:0] s_dat;
  logic              err_o, irq_o;
  logic [31:0]       err_adr_o;
  logic [15:0]       err_cnt_o;

  logic [31:0] sdat [NSLV];
  logic [3:0]  en_mask, noise_mask;
  int          ack_dly, scnt;

  int total, bad;

  // observations from the current transaction
  logic [3:0]  obs_cyc, cyc_seen;
  logic        obs_stb, obs_we;
  logic [3:0]  obs_sel;
  logic [31:0] obs_adr, obs_dat;
  int          lat;
  logic [31:0] rdat;
  logic        ack_after;
  int          acks;

  wb_user_slave_arbiter #(
    .NSLV(NSLV),
    .TIMEOUT(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack), .s_dat_i(s_dat),
    .err_o(err_o), .err_adr_o(err_adr_o), .err_cnt_o(err_cnt_o),
    .err_clr_i(err_clr), .irq_o(irq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign s_dat = {sdat[3], sdat[2], sdat[1], sdat[0]};

  // Slave model: the enabled slave acks after ack_dly WAIT cycles;
  // noise_mask raises acks on other slots while a cycle is open.
  always @(negedge clk) begin
    if (!rst_n || s_cyc_o == '0) begin
      scnt  = 0;
      s_ack = '0;
    end else begin
      s_ack = ((scnt >= ack_dly) ? (s_cyc_o & en_mask) : 4'b0000) | noise_mask;
      scnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Starts at a negedge, ends at a negedge one cycle after the ack.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w);
    cyc = 1'b1; stb = 1'b1; adr = a; wdat = d; sel = s; we = w;
    lat = -1; rdat = '0; cyc_seen = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      cyc_seen = cyc_seen | s_cyc_o;
      if (n == 1) begin
        obs_cyc = s_cyc_o; obs_stb = s_stb_o; obs_we = s_we_o;
        obs_sel = s_sel_o; obs_adr = s_adr_o; obs_dat = s_dat_o;
      end
      if (wbs_ack_o) begin
        lat = n; rdat = wbs_dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(negedge clk);
    ack_after = wbs_ack_o;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; err_clr = 1'b0;
    sel = '0; adr = '0; wdat = '0;
    en_mask = '0; noise_mask = '0; ack_dly = 0;
    for (int k = 0; k < 4; k++) sdat[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",  32'(wbs_ack_o), 0);
    check("rst_dat",  wbs_dat_o, 0);
    check("rst_scyc", 32'(s_cyc_o), 0);
    check("rst_err",  32'(err_o), 0);
    check("rst_cnt",  32'(err_cnt_o), 0);
    check("rst_irq",  32'(irq_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // read slot 1, slave acks after 2 cycles
    en_mask = 4'b0010; ack_dly = 2; sdat[1] = 32'h1234_5678;
    xfer(32'h3000_0104, 32'h0, 4'hF, 1'b0);
    check("rd_lat",   32'(lat), 5);
    check("rd_data",  rdat, 32'h1234_5678);
    check("rd_cyc",   32'(obs_cyc), 32'b0010);
    check("rd_stb",   32'(obs_stb), 1);
    check("rd_adr",   obs_adr, 32'h3000_0104);
    check("rd_pulse", 32'(ack_after), 0);
    check("rd_err",   32'(err_o), 0);

    // write slot 2, slave acks immediately
    en_mask = 4'b0100; ack_dly = 0; sdat[2] = 32'h0BAD_F00D;
    xfer(32'h3000_0200, 32'hA5A5_A5A5, 4'b0011, 1'b1);
    check("wr_lat",  32'(lat), 3);
    check("wr_cyc",  32'(obs_cyc), 32'b0100);
    check("wr_we",   32'(obs_we), 1);
    check("wr_dat",  obs_dat, 32'hA5A5_A5A5);
    check("wr_sel",  32'(obs_sel), 32'b0011);
    check("wr_rdat", rdat, 32'h0BAD_F00D);
    check("wr_err",  32'(err_o), 0);

    // slot 3 never acks; other slots' acks must be ignored
    en_mask = 4'b0000; noise_mask = 4'b0111;
    xfer(32'h3000_0300, 32'h0, 4'hF, 1'b0);
    noise_mask = '0;
    check("to_lat",  32'(lat), 10);
    check("to_data", rdat, 32'hDEAD_BEEF);
    check("to_eadr", err_adr_o, 32'h3000_0300);
    check("to_cnt",  32'(err_cnt_o), 1);
    check("to_err",  32'(err_o), 1);
    check("to_irq",  32'(irq_o), 32'(IRQ_ON));

    // clear
    err_clr = 1'b1; @(posedge clk); @(negedge clk); err_clr = 1'b0;
    check("clr_err", 32'(err_o), 0);
    check("clr_cnt", 32'(err_cnt_o), 0);
    check("clr_irq", 32'(irq_o), 0);

    // unmapped accesses
    xfer(32'h2000_0000, 32'h0, 4'hF, 1'b0);
    check("um1_lat",  32'(lat), 2);
    check("um1_data", rdat, 32'hDEAD_BEEF);
    check("um1_cyc",  32'(cyc_seen), 0);
    xfer(32'h3000_0700, 32'h0, 4'hF, 1'b0);
    check("um2_lat",  32'(lat), 2);
    check("um2_data", rdat, 32'hDEAD_BEEF);
    check("um2_cyc",  32'(cyc_seen), 0);
    check("um_cnt",   32'(err_cnt_o), 2);
    check("um_eadr",  err_adr_o, 32'h3000_0700);
    check("um_irq",   32'(irq_o), 0);

    // master abort in the 3rd WAIT cycle
    en_mask = 4'b0000;
    cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0000; we = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("ab_cyc_on", 32'(s_cyc_o), 32'b0001);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ab_cyc_off", 32'(s_cyc_o), 0);
    check("ab_stb_off", 32'(s_stb_o), 0);
    acks = 0;
    repeat (12) begin @(posedge clk); @(negedge clk); acks += 32'(wbs_ack_o); end
    check("ab_noack", 32'(acks), 0);
    check("ab_cnt",   32'(err_cnt_o), 2);
    en_mask = 4'b0001; ack_dly = 0; sdat[0] = 32'hCAFE_0001;
    xfer(32'h3000_0010, 32'h0, 4'hF, 1'b0);
    check("ab_next_lat",  32'(lat), 3);
    check("ab_next_data", rdat, 32'hCAFE_0001);

    // asynchronous reset during WAIT
    en_mask = 4'b0000;
    cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0100;
    @(posedge clk); @(negedge clk);
    check("rw_cyc_on", 32'(s_cyc_o), 32'b0010);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rw_cyc", 32'(s_cyc_o), 0);
    check("rw_stb", 32'(s_stb_o), 0);
    check("rw_err", 32'(err_o), 0);
    check("rw_cnt", 32'(err_cnt_o), 0);
    check("rw_ack", 32'(wbs_ack_o), 0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0; cyc_seen = '0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      acks += 32'(wbs_ack_o); cyc_seen = cyc_seen | s_cyc_o;
    end
    check("rw_noack", 32'(acks), 0);
    check("rw_nocyc", 32'(cyc_seen), 0);

    // one fault, then clear coinciding with a timeout
    xfer(32'h1000_0000, 32'h0, 4'hF, 1'b0);
    check("pre_cnt", 32'(err_cnt_o), 1);
    cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0300;
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); @(negedge clk); err_clr = 1'b0;
    check("ct_err", 32'(err_o), 1);
    check("ct_cnt", 32'(err_cnt_o), 1);
    check("ct_irq", 32'(irq_o), 32'(IRQ_ON));
    @(posedge clk); @(negedge clk);
    check("ct_ack",  32'(wbs_ack_o), 1);
    check("ct_data", wbs_dat_o, 32'hDEAD_BEEF);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ct_idle_dat", wbs_dat_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
